mips_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register. It consumes the `PCWrite` and `IF_ID_Write` stall controls from the load-use hazard detection unit and the branch/jump redirect from ID. It produces the `IF_ID_RegisterRs`/`IF_ID_RegisterRt` fields that the hazard unit compares against. It also keeps stall and flush event counters for performance debug.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mips_fetch_stage_if.sv | 15 +
 rtl/if_id_reg.sv | 65 ++++++
 rtl/mips_fetch_stage.sv | 94 +++++++++
 tb/tb_mips_fetch_stage.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared constants for the MIPS pipeline front end: instruction width,
//   register-specifier field positions, the NOP encoding, the default reset PC
//   and a saturating-increment helper used by the performance counters.
package mips_pkg;

    localparam int INSTR_W    = 32;
    localparam int REG_ADDR_W = 5;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    // sll $0,$0,0 encodes as all zeros.
    localparam logic [INSTR_W-1:0] NOP_INSTR        = '0;
    localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/mips_fetch_stage_if.sv
// mips_imem_if
//   Instruction-memory bus between the fetch stage and an async-read memory.
//   imem_addr  : byte address of the instruction being fetched (fetch -> mem)
//   imem_rdata : instruction word at imem_addr, same cycle     (mem -> fetch)
//   Modports: master = fetch stage, slave = instruction memory.
interface mips_imem_if;
    import mips_pkg::*;

    logic [INSTR_W-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_addr, input  imem_rdata);
    modport slave  (input  imem_addr, output imem_rdata);

endinterface

// File: rtl/if_id_reg.sv
// if_id_reg
//   IF/ID pipeline register holding the fetched instruction, its PC+4 and a
//   valid bit. A flush clears the register to a NOP bubble and takes priority
//   over the load enable; with load low the contents hold.
//   Ports:
//     clk, rst_n       : clock, asynchronous active-low reset
//     flush            : squash the contents (taken redirect)
//     load             : capture instr_in/pc_plus4_in this edge
//     instr_in         : fetched instruction word
//     pc_plus4_in      : PC+4 of the fetched instruction
//     instr, pc_plus4, valid : registered outputs
module if_id_reg
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               load,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [INSTR_W-1:0] pc_plus4_in,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] pc_plus4,
    output logic               valid
);

    logic [INSTR_W-1:0] instr_q,    instr_d;
    logic [INSTR_W-1:0] pc_plus4_q, pc_plus4_d;
    logic               valid_q,    valid_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; that is what keeps this block from inferring a latch.
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (load) begin
            instr_d    = instr_in;
            pc_plus4_d = pc_plus4_in;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr    = instr_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage
//   Instruction-fetch stage: program counter, next-PC selection, IF/ID
//   register and stall/flush performance counters.
//   Parameters:
//     RESET_PC : PC loaded on reset
//     XLEN     : datapath width (only 32 is supported)
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     PCWrite           : 1 = PC advances, 0 = PC holds (load-use stall)
//     IF_ID_Write       : 1 = IF/ID loads, 0 = IF/ID holds
//     redirect_valid    : taken branch/jump from ID; flushes IF/ID
//     redirect_target   : new PC, low two bits ignored
//     imem              : instruction-memory bus (addr out, rdata in)
//     IF_ID_Instr/PCPlus4/Valid : IF/ID register contents
//     IF_ID_RegisterRs/Rt       : source register fields for the hazard unit
//     stall_count, flush_count  : saturating event counters
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PCWrite,
    input  logic                  IF_ID_Write,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_target,
    mips_imem_if.master           imem,
    output logic [XLEN-1:0]       IF_ID_Instr,
    output logic [XLEN-1:0]       IF_ID_PCPlus4,
    output logic                  IF_ID_Valid,
    output logic [REG_ADDR_W-1:0] IF_ID_RegisterRs,
    output logic [REG_ADDR_W-1:0] IF_ID_RegisterRt,
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic [31:0]     stall_count_q, stall_count_d;
    logic [31:0]     flush_count_q, flush_count_d;

    // Wraps modulo 2^32 by construction.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d          = pc_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (redirect_valid) begin
            // Redirect wins over a stall: the wrong-path fetch is discarded anyway.
            pc_d          = redirect_target & ~32'h3;
            flush_count_d = sat_inc(flush_count_q);
        end else if (!PCWrite) begin
            stall_count_d = sat_inc(stall_count_q);
        end else begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Address comes straight from the PC flop, never from redirect inputs.
    assign imem.imem_addr = pc_q;

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (redirect_valid),
        .load        (IF_ID_Write),
        .instr_in    (imem.imem_rdata),
        .pc_plus4_in (pc_plus4),
        .instr       (IF_ID_Instr),
        .pc_plus4    (IF_ID_PCPlus4),
        .valid       (IF_ID_Valid)
    );

    assign IF_ID_RegisterRs = IF_ID_Instr[RS_HI:RS_LO];
    assign IF_ID_RegisterRt = IF_ID_Instr[RT_HI:RT_LO];
    assign stall_count      = stall_count_q;
    assign flush_count      = flush_count_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb_mips_fetch_stage
//   Directed plus randomized checks of mips_fetch_stage against a behavioural
//   model of the fetch rules, backed by a 64-word instruction memory.
module tb_mips_fetch_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write;
    logic        if_id_write;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] if_id_instr, if_id_pc_plus4;
    logic        if_id_valid;
    logic [4:0]  if_id_rs, if_id_rt;
    logic [31:0] stall_count, flush_count;

    logic [31:0] mem [64];

    mips_imem_if imem ();
    assign imem.imem_rdata = mem[imem.imem_addr[7:2]];

    mips_fetch_stage #(.RESET_PC(32'h0), .XLEN(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .PCWrite          (pc_write),
        .IF_ID_Write      (if_id_write),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .imem             (imem.master),
        .IF_ID_Instr      (if_id_instr),
        .IF_ID_PCPlus4    (if_id_pc_plus4),
        .IF_ID_Valid      (if_id_valid),
        .IF_ID_RegisterRs (if_id_rs),
        .IF_ID_RegisterRt (if_id_rt),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [31:0] m_pc, m_instr, m_pc4, m_stall, m_flush;
    logic        m_valid;

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".imem_addr"}, imem.imem_addr, m_pc);
        check({tag, ".instr"},     if_id_instr,    m_instr);
        check({tag, ".pcplus4"},   if_id_pc_plus4, m_pc4);
        check({tag, ".valid"},     {31'b0, if_id_valid}, {31'b0, m_valid});
        check({tag, ".rs"},        {27'b0, if_id_rs}, {27'b0, m_instr[25:21]});
        check({tag, ".rt"},        {27'b0, if_id_rt}, {27'b0, m_instr[20:16]});
        check({tag, ".stall"},     stall_count,    m_stall);
        check({tag, ".flush"},     flush_count,    m_flush);
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_stall = 32'h0;
        m_flush = 32'h0;
    endtask

    // One clock edge with the given controls; model follows the fetch rules.
    task automatic step(input logic pw, input logic iw, input logic rv,
                        input logic [31:0] tgt, input string tag);
        logic [31:0] fetched;
        pc_write        = pw;
        if_id_write     = iw;
        redirect_valid  = rv;
        redirect_target = tgt;
        fetched = mem[m_pc[7:2]];
        @(posedge clk);
        if (rv) begin
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
            m_pc    = {tgt[31:2], 2'b00};
            if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
        end else begin
            if (iw) begin
                m_instr = fetched;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
            end
            if (pw) m_pc = m_pc + 32'd4;
            else if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h2001_0005;

        // Reset
        rst_n = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");

        // First edge after release fetches RESET_PC
        rst_n = 1'b1;
        step(1, 1, 0, 0, "first_fetch");
        check("first_instr", if_id_instr, 32'h2001_0005);
        check("first_addr",  imem.imem_addr, 32'd4);

        // Free run to 16
        step(1, 1, 0, 0, "run8");
        step(1, 1, 0, 0, "run12");
        step(1, 1, 0, 0, "run16");
        check("run_addr16", imem.imem_addr, 32'd16);
        check("run_stall0", stall_count, 32'd0);

        // Get PC to 8 then stall two cycles
        step(1, 1, 1, 32'h4, "redir4");
        step(1, 1, 0, 0, "to8");
        step(0, 0, 0, 0, "stall1");
        step(0, 0, 0, 0, "stall2");
        check("stall_pc8", imem.imem_addr, 32'd8);
        check("stall_cnt2", stall_count, 32'd2);
        step(1, 1, 0, 0, "resume");
        check("resume_instr", if_id_instr, mem[2]);

        // Redirect overrides stall, unaligned target
        step(0, 0, 1, 32'h0000_0043, "redir_stall");
        check("redir_pc40", imem.imem_addr, 32'h40);
        check("redir_valid0", {31'b0, if_id_valid}, 32'd0);
        step(1, 1, 0, 0, "after_redir");

        // Asymmetric controls
        step(1, 0, 0, 0, "pc_only");
        step(0, 1, 0, 0, "ifid_only");

        // PC wrap
        step(1, 1, 1, 32'hFFFF_FFFC, "to_top");
        step(1, 1, 0, 0, "wrap");
        check("wrap_pc0", imem.imem_addr, 32'h0);
        check("wrap_pc4", if_id_pc_plus4, 32'h0);

        // Randomized controls
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(3) != 0), ($urandom_range(3) != 0),
                 ($urandom_range(5) == 0), $urandom, "rand");
        end

        // Async reset mid-stall with a pending redirect
        step(0, 0, 0, 0, "pre_rst_stall");
        pc_write = 1'b0; if_id_write = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h1234_5678;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check_all("rst_held");
        rst_n = 1'b1;
        step(1, 1, 0, 0, "post_rst_fetch");
        check("post_rst_instr", if_id_instr, 32'h2001_0005);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
